vga_fb_scanout: RTL and testbench

- Downstream video stage of the CPU top level: scans a CPU-written 8-bit RGB332 framebuffer and drives the VGA DAC.
- Generates 640x480@60 timing from the system clock divided by 2, giving a 25 MHz pixel rate from a 50 MHz clock.
- Issues reads to the framebuffer's synchronous read port.
- Outputs registered hsync/vsync, blank_n and 8-bit red/green/blue, aligned to the fetched pixel.

---
 rtl/vga_fb_scanout_if.sv | 27 ++
 rtl/vga_fb_scanout.sv | 108 ++++++++++
 tb/tb_vga_fb_scanout.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read bus and VGA DAC outputs of the scanout stage.
// master = scanout engine, slave = framebuffer RAM / DAC side.
interface vga_fb_scanout_if;
  logic [15:0] fb_addr;
  logic        fb_rd_en;
  logic [7:0]  fb_rdata;
  logic        clk_vga;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;

  modport master (
    output fb_addr, fb_rd_en,
    input  fb_rdata,
    output clk_vga, hsync, vsync, blank_n, red, green, blue, frame_start
  );

  modport slave (
    input  fb_addr, fb_rd_en,
    output fb_rdata,
    input  clk_vga, hsync, vsync, blank_n, red, green, blue, frame_start
  );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scanout of an RGB332 framebuffer: div-by-2 pixel clock, sync timing,
// synchronous framebuffer fetch and registered RGB888 expansion.
module vga_fb_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  vga_fb_scanout_if.master   bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);

  logic            div;
  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;

  logic       active;
  logic       in_img;
  logic       hs_n;
  logic       vs_n;
  logic       hc_last;
  logic       vc_last;
  logic [7:0] pix;

  // Region decode straight from the counters
  always_comb begin
    active  = (hc < HC_W'(H_ACTIVE)) && (vc < VC_W'(V_ACTIVE));
    in_img  = (hc < HC_W'(IMG_W))    && (vc < VC_W'(IMG_H));
    hs_n    = !((hc >= HC_W'(H_ACTIVE + H_FP)) &&
                (hc <  HC_W'(H_ACTIVE + H_FP + H_SYNC)));
    vs_n    = !((vc >= VC_W'(V_ACTIVE + V_FP)) &&
                (vc <  VC_W'(V_ACTIVE + V_FP + V_SYNC)));
    hc_last = (hc == HC_W'(H_TOTAL - 1));
    vc_last = (vc == VC_W'(V_TOTAL - 1));
    pix     = in_img ? bus.fb_rdata : BG_COLOR;
  end

  // Address is held for the whole pixel so the RAM samples it on the non-tick edge
  assign bus.fb_rd_en = in_img & ~reset;
  assign bus.fb_addr  = (in_img & ~reset) ? {8'(vc), 8'(hc)} : 16'h0000;
  assign bus.clk_vga  = div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div             <= 1'b0;
      hc              <= '0;
      vc              <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.blank_n     <= 1'b0;
      bus.red         <= 8'h00;
      bus.green       <= 8'h00;
      bus.blue        <= 8'h00;
      bus.frame_start <= 1'b0;
    end else if (restart) begin
      div             <= 1'b0;
      hc              <= '0;
      vc              <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.blank_n     <= 1'b0;
      bus.red         <= 8'h00;
      bus.green       <= 8'h00;
      bus.blue        <= 8'h00;
      bus.frame_start <= 1'b0;
    end else begin
      div             <= ~div;
      bus.frame_start <= 1'b0;
      if (div) begin
        if (hc_last) begin
          hc <= '0;
          vc <= vc_last ? '0 : vc + VC_W'(1);
        end else begin
          hc <= hc + HC_W'(1);
        end
        bus.frame_start <= hc_last && vc_last;
        bus.hsync       <= hs_n;
        bus.vsync       <= vs_n;
        bus.blank_n     <= active;
        // Replicate the 3/3/2 fields to span the full 8-bit DAC range
        if (active) begin
          bus.red   <= {pix[7:5], pix[7:5], pix[7:6]};
          bus.green <= {pix[4:2], pix[4:2], pix[4:3]};
          bus.blue  <= {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
        end else begin
          bus.red   <= 8'h00;
          bus.green <= 8'h00;
          bus.blue  <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout; vertical timing shrunk to 18 lines so a
// whole frame (28800 clk) fits, horizontal timing kept at 800 pixels.
module tb_vga_fb_scanout;

  logic clk = 1'b0;
  logic rst;
  logic restart;
  int   ecount;
  int   n_vec = 0;
  int   n_err = 0;

  vga_fb_scanout_if bus ();

  vga_fb_scanout #(
    .V_ACTIVE (12),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .IMG_H    (8),
    .BG_COLOR (8'hE3)
  ) dut (
    .clk     (clk),
    .reset   (rst),
    .restart (restart),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;

  function automatic logic [7:0] ram_data(input logic [15:0] a);
    case (a)
      16'h0000: ram_data = 8'hE0;
      16'h0001: ram_data = 8'h1F;
      default:  ram_data = a[15:8] + a[7:0];
    endcase
  endfunction

  // Synchronous-read RAM; X outside the image
  always @(posedge clk)
    bus.fb_rdata <= bus.fb_rd_en ? ram_data(bus.fb_addr) : 8'hxx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  int   h_fall1 = -1, h_fall2 = -1, h_rise1 = -1;
  int   v_fall = -1, v_rise = -1;
  int   fs_first = -1, fs_cnt = 0, fs2_first = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  initial begin
    rst     = 1'b1;
    restart = 1'b0;
    @(negedge clk);
    chk("rd_en_in_reset", 32'(bus.fb_rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hsync", 32'(bus.hsync), 32'd1);
    chk("rst_vsync", 32'(bus.vsync), 32'd1);
    chk("rst_blank", 32'(bus.blank_n), 32'd0);
    chk("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    chk("rst_fs", 32'(bus.frame_start), 32'd0);
    chk("rst_clkvga", 32'(bus.clk_vga), 32'd0);

    // First frame: pixel path, line/frame timing
    while (ecount < 28810) begin
      @(posedge clk);
      @(negedge clk);
      if (prev_hs && !bus.hsync) begin
        if (h_fall1 < 0) h_fall1 = ecount;
        else if (h_fall2 < 0) h_fall2 = ecount;
      end
      if (!prev_hs && bus.hsync && h_rise1 < 0) h_rise1 = ecount;
      if (prev_vs && !bus.vsync && v_fall < 0) v_fall = ecount;
      if (!prev_vs && bus.vsync && v_rise < 0) v_rise = ecount;
      prev_hs = bus.hsync;
      prev_vs = bus.vsync;
      if (bus.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = ecount;
      end
      case (ecount)
        1: begin
          chk("e1_clkvga", 32'(bus.clk_vga), 32'd1);
          chk("e1_blank", 32'(bus.blank_n), 32'd0);
        end
        2: begin
          chk("e2_clkvga", 32'(bus.clk_vga), 32'd0);
          chk("p00_blank", 32'(bus.blank_n), 32'd1);
          chk("p00_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hFF0000);
          chk("p10_addr", 32'(bus.fb_addr), 32'h0001);
          chk("p10_rd_en", 32'(bus.fb_rd_en), 32'd1);
        end
        4: begin
          chk("p10_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h00FFFF);
          chk("p10_blank", 32'(bus.blank_n), 32'd1);
        end
        8004: chk("p2_5_addr", 32'(bus.fb_addr), 32'h0502);
        8006: chk("p2_5_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0024FF);
        14404: chk("p2_9_rd_en", 32'(bus.fb_rd_en), 32'd0);
        14406: begin
          chk("p2_9_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hFF00FF);
          chk("p2_9_blank", 32'(bus.blank_n), 32'd1);
        end
        16600: begin
          chk("p300_rd_en", 32'(bus.fb_rd_en), 32'd0);
          chk("p300_addr", 32'(bus.fb_addr), 32'h0000);
        end
        16602: begin
          chk("p300_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hFF00FF);
          chk("p300_known", 32'($isunknown({bus.red, bus.green, bus.blue})), 32'd0);
          chk("p300_blank", 32'(bus.blank_n), 32'd1);
        end
        17402: begin
          chk("p700_blank", 32'(bus.blank_n), 32'd0);
          chk("p700_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
          chk("p700_hsync", 32'(bus.hsync), 32'd0);
        end
        default: ;
      endcase
    end
    chk("hs_fall1", 32'(h_fall1), 32'd1314);
    chk("hs_rise1", 32'(h_rise1), 32'd1506);
    chk("hs_fall2", 32'(h_fall2), 32'd2914);
    chk("vs_fall", 32'(v_fall), 32'd22402);
    chk("vs_rise", 32'(v_rise), 32'd25602);
    chk("fs_first", 32'(fs_first), 32'd28800);
    chk("fs_count", 32'(fs_cnt), 32'd1);

    // Restart at (400,5) of the second frame
    while (ecount < 37600) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_blank", 32'(bus.blank_n), 32'd1);
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
    chk("rs_hsync", 32'(bus.hsync), 32'd1);
    chk("rs_blank", 32'(bus.blank_n), 32'd0);
    chk("rs_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    chk("rs_clkvga", 32'(bus.clk_vga), 32'd0);
    chk("rs_addr", 32'(bus.fb_addr), 32'h0000);
    chk("rs_fs", 32'(bus.frame_start), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rs_addr_p1", 32'(bus.fb_addr), 32'h0001);
    while (ecount < 66410) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.frame_start && fs2_first < 0) fs2_first = ecount;
    end
    chk("fs_after_restart", 32'(fs2_first), 32'd66401);

    // Async reset in the middle of an hsync pulse
    while (ecount < 67800) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_hsync_low", 32'(bus.hsync), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_hsync", 32'(bus.hsync), 32'd1);
    chk("async_rst_blank", 32'(bus.blank_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
